// File: rtl/core_inst_seq.sv
// rtl/core_inst_seq.sv - per-kij instruction sequencer driving the 34-bit core inst bus
// Weights xmem->L0->PEs, activations xmem->L0, execute, then drain OFIFO psums into pmem.
module core_inst_seq #(
  parameter int          col      = 8,
  parameter int          row      = 8,
  parameter int          len_nij  = 36,
  parameter int          len_kij  = 9,
  parameter int          LOAD_CYC = col + row - 1,
  parameter int          GAP_CYC  = 10,
  parameter logic [10:0] WBASE    = 11'h400,
  parameter logic [10:0] PBASE    = 11'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
  localparam logic [7:0]  COL_C     = 8'(col);
  localparam logic [7:0]  NIJ_C     = 8'(len_nij);
  localparam logic [7:0]  LOAD_LAST = 8'(LOAD_CYC - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYC - 1);
  localparam logic [3:0]  KIJ_LAST  = 4'(len_kij - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LD, S_GAP, S_X_L0, S_EXEC, S_DRAIN, S_OF_RD, S_NEXT, S_DONE
  } state_t;

  state_t      state, nxt;
  logic [7:0]  cnt, cnt_n;
  logic [7:0]  rd_cnt, rd_cnt_n;
  logic [7:0]  wr_cnt, wr_cnt_n;
  logic        pend, pend_n;
  logic [3:0]  kij_n;
  logic [33:0] word;
  logic [10:0] w_addr, p_addr;
  logic        rd;

  assign w_addr = WBASE + 11'(kij) * 11'(col) + 11'(cnt);
  assign p_addr = PBASE + 11'(kij) * 11'(len_nij) + 11'(wr_cnt);

  always_comb begin
    nxt      = state;
    cnt_n    = cnt;
    rd_cnt_n = rd_cnt;
    wr_cnt_n = wr_cnt;
    pend_n   = pend;
    kij_n    = kij;
    word     = IDLE_WORD;
    rd       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt   = S_W_L0;
          cnt_n = 8'd0;
          kij_n = 4'd0;
        end
      end
      S_W_L0: begin
        if (cnt < COL_C) begin
          word[19]   = 1'b0;
          word[17:7] = w_addr;
        end
        // L0 write trails the xmem read by the SRAM read latency
        if (cnt != 8'd0) word[2] = 1'b1;
        if (cnt == COL_C) begin
          nxt   = S_W_LD;
          cnt_n = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_W_LD: begin
        word[3] = 1'b1;
        word[0] = 1'b1;
        if (cnt == LOAD_LAST) begin
          nxt   = S_GAP;
          cnt_n = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          nxt   = S_X_L0;
          cnt_n = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_X_L0: begin
        if (cnt < NIJ_C) begin
          word[19]   = 1'b0;
          word[17:7] = 11'(cnt);
        end
        if (cnt != 8'd0) word[2] = 1'b1;
        if (cnt == NIJ_C) begin
          nxt   = S_EXEC;
          cnt_n = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_EXEC: begin
        word[3] = 1'b1;
        word[1] = 1'b1;
        if (cnt == NIJ_C - 8'd1) begin
          nxt   = S_DRAIN;
          cnt_n = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_DRAIN: begin
        if (ofifo_valid) begin
          nxt      = S_OF_RD;
          rd_cnt_n = 8'd0;
          wr_cnt_n = 8'd0;
          pend_n   = 1'b0;
        end
      end
      S_OF_RD: begin
        rd       = ofifo_valid && (rd_cnt < NIJ_C);
        word[6]  = rd;
        rd_cnt_n = rd_cnt + {7'd0, rd};
        pend_n   = rd;
        // pend marks a row read last cycle whose data is now on the OFIFO output
        if (pend) begin
          word[32]    = 1'b0;
          word[31]    = 1'b0;
          word[30:20] = p_addr;
          wr_cnt_n    = wr_cnt + 8'd1;
          if (wr_cnt == NIJ_C - 8'd1) nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (kij == KIJ_LAST) begin
          nxt = S_DONE;
        end else begin
          nxt   = S_W_L0;
          kij_n = kij + 4'd1;
          cnt_n = 8'd0;
        end
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 8'd0;
      rd_cnt <= 8'd0;
      wr_cnt <= 8'd0;
      pend   <= 1'b0;
      kij    <= 4'd0;
      inst   <= IDLE_WORD;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_n;
      rd_cnt <= rd_cnt_n;
      wr_cnt <= wr_cnt_n;
      pend   <= pend_n;
      kij    <= kij_n;
      inst   <= word;
      busy   <= (nxt != S_IDLE);
      done   <= (nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// tb/tb_core_inst_seq.sv - directed bench for core_inst_seq
module tb_core_inst_seq;

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic [33:0] inst;
  logic        busy, done;
  logic [3:0]  kij;

  int n_chk = 0;
  int n_fail = 0;

  core_inst_seq dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .kij(kij)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // observer of the inst bus: pmem writes, weight reads, rd/write pairing
  logic        v_at_edge = 1'b0;
  logic        prev_rd = 1'b0;
  logic [10:0] pq[$];
  logic [10:0] wq[$];
  int          bad_rd = 0;
  int          bad_wr = 0;
  int          rd_total = 0;
  int          done_total = 0;

  always @(posedge clk) v_at_edge <= ofifo_valid;

  always @(negedge clk) begin
    if (!reset) begin
      if (!inst[32] && !inst[31]) begin
        pq.push_back(inst[30:20]);
        if (!prev_rd) bad_wr++;
      end
      if (inst[6]) begin
        rd_total++;
        if (!v_at_edge) bad_rd++;
      end
      if (!inst[19] && inst[18] && inst[17:7] >= 11'h400) wq.push_back(inst[17:7]);
      if (done) done_total++;
      prev_rd = inst[6];
    end else begin
      prev_rd = 1'b0;
    end
  end

  function automatic logic [33:0] exp_word(input int i);
    logic [33:0] w;
    int          j;
    w = IDLE_WORD;
    if (i < 9) begin
      if (i < 8) begin
        w[19]   = 1'b0;
        w[17:7] = 11'h400 + 11'(i);
      end
      if (i >= 1) w[2] = 1'b1;
    end else if (i < 24) begin
      w[3] = 1'b1;
      w[0] = 1'b1;
    end else if (i >= 34 && i < 71) begin
      j = i - 34;
      if (j < 36) begin
        w[19]   = 1'b0;
        w[17:7] = 11'(j);
      end
      if (j >= 1) w[2] = 1'b1;
    end else if (i >= 71) begin
      w[3] = 1'b1;
      w[1] = 1'b1;
    end
    return w;
  endfunction

  int pmark, wmark, rmark, dmark, errs, cyc;
  bool_t_dummy_unused_guard u_guard ();

  initial begin
    // reset is asynchronous: visible before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_inst", inst, IDLE_WORD);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_kij", kij, 0);
    @(negedge clk);
    reset = 1'b0;

    // first run, aborted by reset in the middle of EXEC
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!inst[1] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_exec", inst[1], 1);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_inst", inst, IDLE_WORD);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle_hold", busy, 0);

    // second run: exact inst sequence of kij 0
    pmark = pq.size();
    wmark = wq.size();
    rmark = rd_total;
    dmark = done_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_kij", kij, 0);
    check("start_inst", inst, IDLE_WORD);
    for (int i = 0; i < 107; i++) begin
      @(negedge clk);
      check($sformatf("seq%0d", i), inst, exp_word(i));
    end

    // rest of the run with ofifo_valid toggling, stray start mid-run and in DONE
    cyc = 0;
    while (!done && cyc < 6000) begin
      @(negedge clk);
      ofifo_valid = ~ofifo_valid;
      start = (cyc == 300);
      cyc++;
    end
    check("done_seen", done, 1);
    check("done_kij", kij, 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ofifo_valid = 1'b1;
    check("post_done_busy", busy, 0);
    check("post_done_pulse", done, 0);
    repeat (3) @(negedge clk);
    check("start_in_done_ignored", busy, 0);
    check("post_done_inst", inst, IDLE_WORD);

    check("pmem_count", pq.size() - pmark, 324);
    errs = 0;
    for (int i = 0; i < 324 && pmark + i < pq.size(); i++)
      if (pq[pmark + i] != 11'(i)) errs++;
    check("pmem_contig", errs, 0);
    if (pq.size() >= pmark + 324) begin
      check("pmem_kij3_first", pq[pmark + 108], 108);
      check("pmem_kij3_last", pq[pmark + 143], 143);
      check("pmem_last", pq[pmark + 323], 323);
    end else begin
      check("pmem_short", pq.size() - pmark, 324);
    end
    check("wt_count", wq.size() - wmark, 72);
    for (int j = 0; j < 8; j++)
      if (wmark + 24 + j < wq.size())
        check($sformatf("wt_kij3_%0d", j), wq[wmark + 24 + j], 11'h418 + 11'(j));
      else
        check($sformatf("wt_kij3_missing_%0d", j), wq.size(), wmark + 24 + j + 1);
    check("rd_count", rd_total - rmark, 324);
    check("rd_only_when_valid", bad_rd, 0);
    check("wr_follows_rd", bad_wr, 0);
    check("done_pulses", done_total - dmark, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

module bool_t_dummy_unused_guard;
endmodule
